// File: rtl/sap_pkg.sv
// Shared SAP definitions: default datapath widths, opcode type and opcode constants.
package sap_pkg;

  localparam int unsigned SAP_WORD_W = 8;
  localparam int unsigned SAP_OPC_W  = 4;

  typedef logic [SAP_OPC_W-1:0] opcode_t;

  localparam opcode_t LDA = 4'h0;
  localparam opcode_t ADD = 4'h1;
  localparam opcode_t SUB = 4'h2;
  localparam opcode_t OUT = 4'hE;
  localparam opcode_t HLT = 4'hF;

endpackage

// File: rtl/ir_queue_ctrl.sv
// Prefetch queue bookkeeping: read/write pointers, occupancy and qualification of push/pop
// requests, including the overflow/underflow events the top level latches into sticky flags.
module ir_queue_ctrl #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_req,
  input  logic             pop_req,
  input  logic             bypass_take,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             push,
  output logic             pop,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Qualify requests; flush overrides everything, bypassed words never touch the queue.
  always_comb begin
    push      = 1'b0;
    pop       = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (!flush && !bypass_take) begin
      // A pop in the same cycle frees the slot, so a full queue can still accept a word.
      push      = push_req && (!full || pop_req);
      pop       = pop_req && !empty;
      overflow  = push_req && full && !pop_req;
      underflow = pop_req && empty;
    end
  end

  // Next-state pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/instruction_queue_register.sv
// SAP instruction register with a DEPTH-entry prefetch queue. Words are captured from the
// W-bus, the head opcode goes to the controller and the head operand can be driven back onto
// the W-bus. Define IR_BYPASS_EN to forward a word straight from the W-bus to the controller
// when the queue is empty (zero-latency fetch, consumable by advance without being stored).
module instruction_queue_register
  import sap_pkg::*;
#(
  parameter int unsigned WORD_W = SAP_WORD_W,
  parameter int unsigned OPC_W  = SAP_OPC_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_i,
  input  logic              output_to_bus,
  input  logic              advance,
  input  logic              flush,
  output logic [OPC_W-1:0]  controller_input,
  output logic              instr_valid,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic              err_conflict,
  inout  wire  [WORD_W-1:0] w_bus
);

  localparam int unsigned OPR_W = WORD_W - OPC_W;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] head_word;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              push, pop, overflow, underflow;
  logic              push_req, conflict, bypass_take;

  assign conflict = load_i && output_to_bus;
  assign push_req = load_i && !output_to_bus;

`ifdef IR_BYPASS_EN
  assign bypass_take = empty && push_req && advance;
`else
  assign bypass_take = 1'b0;
`endif

  ir_queue_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .push_req    (push_req),
    .pop_req     (advance),
    .bypass_take (bypass_take),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .push        (push),
    .pop         (pop),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Queue storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr] <= w_bus;
  end

  assign head_word = mem_q[rd_ptr];

  // Sticky error flags; only reset clears them, a flush cycle raises none.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_conflict  <= 1'b0;
    end else begin
      if (overflow)            err_overflow  <= 1'b1;
      if (underflow)           err_underflow <= 1'b1;
      if (conflict && !flush)  err_conflict  <= 1'b1;
    end
  end

  // Head opcode to the controller, optionally bypassed from the bus when the queue is empty.
  always_comb begin
    controller_input = '0;
    instr_valid      = 1'b0;
    if (!empty) begin
      controller_input = head_word[WORD_W-1 -: OPC_W];
      instr_valid      = 1'b1;
    end
`ifdef IR_BYPASS_EN
    else if (push_req) begin
      controller_input = w_bus[WORD_W-1 -: OPC_W];
      instr_valid      = 1'b1;
    end
`endif
  end

  // Never drive the bus from an empty queue.
  assign w_bus = (output_to_bus && !empty) ? {{OPC_W{1'b0}}, head_word[OPR_W-1:0]}
                                           : {WORD_W{1'bz}};

  // Both pops and the pop bookkeeping are consumed inside the controller.
  logic unused_pop;
  assign unused_pop = pop;

endmodule
